// File: rtl/debounce_pkg.sv
// Shared types and constants for the slide-switch / push-button debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LO,
      WAIT_HI,
      ST_HI,
      WAIT_LO
   } db_state_t;

   localparam int MIN_STABLE = 2;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchronizer, stability counter, level FSM, edge pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_raw,
   output logic sw_db,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [1:0]       sync;
   logic             s;
   logic [CNT_W-1:0] cnt;
   db_state_t        state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], sw_raw};
      end
   end

   assign s = sync[1];

   // Any opposite sample while waiting drops back to the stable state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_LO;
         cnt   <= '0;
         sw_db <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         unique case (state)
            ST_LO: begin
               if (s) begin
                  state <= WAIT_HI;
                  cnt   <= '0;
               end
            end
            WAIT_HI: begin
               if (!s) begin
                  state <= ST_LO;
               end else if (cnt == LAST) begin
                  state <= ST_HI;
                  sw_db <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HI: begin
               if (!s) begin
                  state <= WAIT_LO;
                  cnt   <= '0;
               end
            end
            WAIT_LO: begin
               if (s) begin
                  state <= ST_HI;
               end else if (cnt == LAST) begin
                  state <= ST_LO;
                  sw_db <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_LO;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_CH raw board switches; each channel is an independent debounce_channel.
module switch_debouncer
   import debounce_pkg::*;
#(
   parameter int N_CH          = 2,
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] sw_raw,
   output logic [N_CH-1:0] sw_db,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall
);

   if (STABLE_CYCLES < MIN_STABLE) begin : g_bad_param
      $error("switch_debouncer: STABLE_CYCLES must be >= 2");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .sw_raw (sw_raw[i]),
         .sw_db  (sw_db[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized + directed bench for switch_debouncer with a queue scoreboard.
module tb_switch_debouncer;

   localparam int N = 2;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] sw_raw = '0;
   logic [N-1:0] sw_db;
   logic [N-1:0] rise;
   logic [N-1:0] fall;

   always #5 clk = ~clk;

   switch_debouncer #(
      .N_CH          (N),
      .STABLE_CYCLES (S)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sw_raw (sw_raw),
      .sw_db  (sw_db),
      .rise   (rise),
      .fall   (fall)
   );

   typedef struct packed {
      logic [N-1:0] db;
      logic [N-1:0] ri;
      logic [N-1:0] fa;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   // Reference: s is raw delayed two samples; the level flips once the
   // last S+1 samples of s all disagree with the current level.
   logic [N-1:0] m_db = '0;
   logic [N-1:0] p1 = '0;
   logic [N-1:0] p2 = '0;
   bit           hist[N][$];

   always @(posedge clk) begin
      exp_t         e;
      logic [N-1:0] s;
      bit           all_opp;
      e = '0;
      if (rst) begin
         m_db = '0;
         p1   = '0;
         p2   = '0;
         for (int i = 0; i < N; i++) hist[i].delete();
      end else begin
         s  = p2;
         p2 = p1;
         p1 = sw_raw;
         for (int i = 0; i < N; i++) begin
            hist[i].push_back(s[i]);
            if (hist[i].size() > S + 1) void'(hist[i].pop_front());
            if (hist[i].size() == S + 1) begin
               all_opp = 1'b1;
               foreach (hist[i][j])
                  if (hist[i][j] == m_db[i]) all_opp = 1'b0;
               if (all_opp) begin
                  m_db[i] = ~m_db[i];
                  if (m_db[i]) e.ri[i] = 1'b1;
                  else         e.fa[i] = 1'b1;
               end
            end
         end
      end
      e.db = m_db;
      sbq.push_back(e);
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      tests++;
      if (sbq.size() == 0) begin
         fails++;
         $display("FAIL sb_empty t=%0t no expected entry", $time);
      end else begin
         e = sbq.pop_front();
         if ({sw_db, rise, fall} !== e) begin
            fails++;
            $display("FAIL sb t=%0t got db=%b rise=%b fall=%b want db=%b rise=%b fall=%b",
                     $time, sw_db, rise, fall, e.db, e.ri, e.fa);
         end
         tests++;
         if ((sw_db[0] & sw_db[1]) !== (e.db[0] & e.db[1])) begin
            fails++;
            $display("FAIL andgate t=%0t got %b want %b",
                     $time, sw_db[0] & sw_db[1], e.db[0] & e.db[1]);
         end
      end
   end

   task automatic hold(input logic [N-1:0] v, input int n);
      sw_raw = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rst(input int n);
      rst = 1'b1;
      #1;
      tests++;
      if ({sw_db, rise, fall} !== '0) begin
         fails++;
         $display("FAIL async_rst t=%0t got db=%b rise=%b fall=%b want all 0",
                  $time, sw_db, rise, fall);
      end
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      sw_raw = 2'b11;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      hold(2'b11, 12);
      hold(2'b00, 12);
      hold(2'b01, 12);
      hold(2'b00, 12);
      for (int k = 0; k < 8; k++) hold(k[0] ? 2'b00 : 2'b01, 1);
      hold(2'b00, 12);
      hold(2'b10, 3);
      hold(2'b00, 12);
      hold(2'b01, 2);
      hold(2'b11, 12);
      pulse_rst(1);
      hold(2'b11, 12);
      hold(2'b00, 12);
      hold(2'b01, 4);
      pulse_rst(1);
      hold(2'b01, 12);
      hold(2'b00, 12);
      for (int seg = 0; seg < 40; seg++) begin
         int mode;
         mode = int'($urandom_range(0, 14));
         if (mode == 0) begin
            pulse_rst(int'($urandom_range(1, 2)));
         end else if (mode < 7) begin
            hold(N'($urandom), int'($urandom_range(1, 12)));
         end else begin
            repeat ($urandom_range(1, 8)) hold(N'($urandom), 1);
         end
      end
      hold(2'b00, 12);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
